// File: rtl/wasm_pkg.sv
// Shared definitions for the WebAssembly front end and execute stage.
// Opcodes, fault codes, immediate classes, FSM states, opcode->class decode.
package wasm_pkg;

    localparam logic [7:0] OP_UNREACHABLE = 8'h00;
    localparam logic [7:0] OP_BR          = 8'h0C;
    localparam logic [7:0] OP_BR_IF       = 8'h0D;
    localparam logic [7:0] OP_CALL        = 8'h10;
    localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
    localparam logic [7:0] OP_LOCAL_SET   = 8'h21;
    localparam logic [7:0] OP_LOCAL_TEE   = 8'h22;
    localparam logic [7:0] OP_I32_CONST   = 8'h41;
    localparam logic [7:0] OP_I64_CONST   = 8'h42;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_LEB_LONG  = 2'd1;
    localparam logic [1:0] FAULT_I64_NARROW = 2'd2;

    localparam logic [3:0] LEB_MAX_32 = 4'd5;
    localparam logic [3:0] LEB_MAX_64 = 4'd10;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_U32,
        IMM_S32,
        IMM_S64
    } imm_class_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_GAP,
        S_IMM,
        S_EMIT,
        S_FAULT
    } fd_state_e;

    function automatic imm_class_e imm_class(input logic [7:0] op);
        imm_class_e c;
        unique case (1'b1)
            (op == OP_BR), (op == OP_BR_IF), (op == OP_CALL),
            (op == OP_LOCAL_GET), (op == OP_LOCAL_SET),
            (op == OP_LOCAL_TEE):   c = IMM_U32;
            (op == OP_I32_CONST):   c = IMM_S32;
            (op == OP_I64_CONST):   c = IMM_S64;
            default:                c = IMM_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] leb_max(input imm_class_e c);
        return (c == IMM_S64) ? LEB_MAX_64 : LEB_MAX_32;
    endfunction

endpackage

// File: rtl/leb128_accum.sv
// Sequential LEB128 accumulator: one byte per byte_valid, with sign fill.
// Ports: clear, byte_valid, in_byte, cls in; value, done, overflow, count out.
module leb128_accum
    import wasm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  in_byte,
    input  imm_class_e  cls,
    output logic [63:0] value,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  count
);

    logic [6:0]  shamt;
    logic [63:0] part;
    logic [63:0] fill;
    logic        is_signed;
    logic        last;
    logic [63:0] value_n;

    always_comb begin
        shamt     = 7'(count) * 7'd7;
        part      = {57'b0, in_byte[6:0]} << shamt;
        // ones from bit 7(k+1) upward; shifts past 63 leave nothing
        fill      = ~64'b0 << (shamt + 7'd7);
        is_signed = (cls == IMM_S32) || (cls == IMM_S64);
        last      = !in_byte[7];
        value_n   = value | part;
        if (is_signed && last && in_byte[6]) begin
            value_n = value_n | fill;
        end
        overflow  = byte_valid && (count >= leb_max(cls));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            done  <= 1'b0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            done  <= 1'b0;
            count <= '0;
        end else if (byte_valid && !overflow) begin
            value <= value_n;
            done  <= last;
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/wasm_fetch_decode.sv
// Fetch/decode front end: opcode fetch, LEB128 immediates, redirect, faults.
// Ports: code_base/start/redirect in; addr/memory_read_en/data_out/memory_ready
// memory handshake; instr_* valid/ready to execute; fault/fault_code sticky.
module wasm_fetch_decode
    import wasm_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 IMM_W    = 64,
    parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] code_base,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] addr,
    output logic              memory_read_en,
    input  logic [7:0]        data_out,
    input  logic              memory_ready,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [IMM_W-1:0]  instr_imm,
    output logic              instr_has_imm,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam bit NARROW = (IMM_W == 32);

    fd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rpc_q, rpc_sel;
    logic              pend_q;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] op_pc_q;
    imm_class_e        cls_q, op_cls;

    logic              apply;
    logic              op_cap, imm_cap, load_out;
    logic              rd_en_d;
    logic [ADDR_W-1:0] addr_d;
    logic              fault_d;
    logic [1:0]        code_d;
    logic              gap_more;
    logic [63:0]       imm_fmt;

    logic [63:0]       acc_value;
    logic              acc_done, acc_overflow;
    logic [3:0]        acc_count;

    // A pending redirect waits out an in-flight read so its byte is dropped.
    assign apply   = (pend_q || redirect_valid) &&
                     (!memory_read_en || memory_ready);
    assign rpc_sel = redirect_valid ? redirect_pc : rpc_q;
    assign op_cls  = imm_class(data_out);
    // Another immediate byte is due if none arrived yet or the last continued.
    assign gap_more = (cls_q != IMM_NONE) &&
                      ((acc_count == 4'd0) || !acc_done);

    leb128_accum u_leb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (op_cap || apply),
        .byte_valid (imm_cap),
        .in_byte    (data_out),
        .cls        (cls_q),
        .value      (acc_value),
        .done       (acc_done),
        .overflow   (acc_overflow),
        .count      (acc_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (apply) begin
            state_d = S_FETCH_OP;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_FETCH_OP;
                end
                S_FETCH_OP: begin
                    if (memory_ready) begin
                        state_d = (NARROW && op_cls == IMM_S64) ?
                                  S_FAULT : S_GAP;
                    end
                end
                S_GAP: begin
                    if (!memory_ready) begin
                        state_d = gap_more ? S_IMM : S_EMIT;
                    end
                end
                S_IMM: begin
                    if (memory_ready) begin
                        state_d = acc_overflow ? S_FAULT : S_GAP;
                    end
                end
                S_EMIT: begin
                    if (instr_ready) state_d = S_FETCH_OP;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_cap   = !apply && (state_q == S_FETCH_OP) && memory_ready;
        imm_cap  = !apply && (state_q == S_IMM) && memory_ready;
        load_out = (state_q == S_GAP) && (state_d == S_EMIT);

        pc_d = pc_q;
        if (apply) begin
            pc_d = rpc_sel;
        end else if (op_cap || imm_cap) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        base_d = base_q;
        if (apply || (state_q == S_IDLE && start)) begin
            base_d = code_base;
        end

        rd_en_d = (state_d == S_FETCH_OP) || (state_d == S_IMM);
        addr_d  = rd_en_d ? (base_d + pc_d) : addr;

        fault_d = (state_d == S_FAULT);
        code_d  = FAULT_NONE;
        if (state_d == S_FAULT) begin
            unique case (state_q)
                S_FETCH_OP: code_d = FAULT_I64_NARROW;
                S_IMM:      code_d = FAULT_LEB_LONG;
                default:    code_d = fault_code;
            endcase
        end

        unique case (cls_q)
            IMM_U32: imm_fmt = {32'b0, acc_value[31:0]};
            IMM_S32: imm_fmt = {{32{acc_value[31]}}, acc_value[31:0]};
            IMM_S64: imm_fmt = acc_value;
            default: imm_fmt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= PC_RESET;
            base_q         <= '0;
            rpc_q          <= '0;
            pend_q         <= 1'b0;
            op_q           <= '0;
            op_pc_q        <= '0;
            cls_q          <= IMM_NONE;
            addr           <= '0;
            memory_read_en <= 1'b0;
            instr_valid    <= 1'b0;
            instr_opcode   <= '0;
            instr_imm      <= '0;
            instr_has_imm  <= 1'b0;
            instr_pc       <= '0;
            fault          <= 1'b0;
            fault_code     <= FAULT_NONE;
        end else begin
            pc_q           <= pc_d;
            base_q         <= base_d;
            pend_q         <= (pend_q || redirect_valid) && !apply;
            if (redirect_valid) rpc_q <= redirect_pc;
            if (op_cap) begin
                op_q    <= data_out;
                op_pc_q <= pc_q;
                cls_q   <= op_cls;
            end
            addr           <= addr_d;
            memory_read_en <= rd_en_d;
            instr_valid    <= (state_d == S_EMIT);
            if (load_out) begin
                instr_opcode  <= op_q;
                instr_imm     <= imm_fmt[IMM_W-1:0];
                instr_has_imm <= (cls_q != IMM_NONE);
                instr_pc      <= op_pc_q;
            end
            fault          <= fault_d;
            fault_code     <= code_d;
        end
    end

endmodule

// File: tb/tb_wasm_fetch_decode.sv
// Self-checking bench for wasm_fetch_decode.
// Byte memory model with adjustable latency; table vectors plus corner cases.
module tb_wasm_fetch_decode;

    localparam int          ADDR_W = 32;
    localparam int          IMM_W  = 64;
    localparam logic [31:0] CB     = 32'h100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] code_base;
    logic              start;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] addr;
    logic              memory_read_en;
    logic [7:0]        data_out;
    logic              memory_ready;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_opcode;
    logic [IMM_W-1:0]  instr_imm;
    logic              instr_has_imm;
    logic [ADDR_W-1:0] instr_pc;
    logic              fault;
    logic [1:0]        fault_code;

    wasm_fetch_decode #(
        .ADDR_W   (ADDR_W),
        .IMM_W    (IMM_W),
        .PC_RESET ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .code_base      (code_base),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .addr           (addr),
        .memory_read_en (memory_read_en),
        .data_out       (data_out),
        .memory_ready   (memory_ready),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_imm      (instr_imm),
        .instr_has_imm  (instr_has_imm),
        .instr_pc       (instr_pc),
        .fault          (fault),
        .fault_code     (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] bytes;
        int          len;
        logic [7:0]  op;
        logic [63:0] imm;
        logic        has;
    } vec_t;

    logic [7:0]  mem [256];
    logic [31:0] rd_q [$];
    int          lat = 0;
    int          wcnt;
    int          n_chk = 0;
    int          n_fail = 0;

    // one-cycle memory_ready pulse after 'lat' extra cycles of request
    initial begin
        memory_ready = 1'b0;
        data_out     = 8'h00;
        wcnt         = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || memory_ready) begin
                memory_ready = 1'b0;
                wcnt         = 0;
            end else if (memory_read_en) begin
                if (wcnt < lat) begin
                    wcnt++;
                end else begin
                    memory_ready = 1'b1;
                    data_out     = mem[8'(addr - CB)];
                    rd_q.push_back(addr);
                    wcnt         = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected instr_valid", name);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        code_base      = CB;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_q.delete();
    endtask

    task automatic pulse_start();
        code_base = CB;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " addr"},  64'(addr), 64'h0);
        chk({tag, " rd_en"}, 64'(memory_read_en), 64'h0);
        chk({tag, " valid"}, 64'(instr_valid), 64'h0);
        chk({tag, " op"},    64'(instr_opcode), 64'h0);
        chk({tag, " imm"},   instr_imm, 64'h0);
        chk({tag, " has"},   64'(instr_has_imm), 64'h0);
        chk({tag, " pc"},    64'(instr_pc), 64'h0);
        chk({tag, " fault"}, {62'b0, fault_code} | 64'(fault), 64'h0);
    endtask

    vec_t vt [11];

    initial begin
        bit          ok;
        int          pos;
        int          bad;
        logic [7:0]  s_op;
        logic [63:0] s_imm;
        logic        s_has;
        logic [31:0] s_pc;

        vt[0]  = '{80'h7F_41, 2, 8'h41, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vt[1]  = '{80'h7F_80_41, 3, 8'h41, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
        vt[2]  = '{80'h26_8E_E5_41, 4, 8'h41, 64'd624485, 1'b1};
        vt[3]  = '{80'h03_10, 2, 8'h10, 64'd3, 1'b1};
        vt[4]  = '{80'h6A, 1, 8'h6A, 64'd0, 1'b0};
        vt[5]  = '{80'h0F_FF_FF_FF_FF_21, 6, 8'h21,
                   64'h0000_0000_FFFF_FFFF, 1'b1};
        vt[6]  = '{80'h78_BB_C0_42, 4, 8'h42, 64'hFFFF_FFFF_FFFE_1DC0, 1'b1};
        vt[7]  = '{80'h00, 1, 8'h00, 64'd0, 1'b0};
        vt[8]  = '{80'h00_0C, 2, 8'h0C, 64'd0, 1'b1};
        vt[9]  = '{80'h01_80_80_80_80_80_80_80_80_42, 10, 8'h42,
                   64'h0100_0000_0000_0000, 1'b1};
        vt[10] = '{80'h0F_FF_FF_FF_FF_41, 6, 8'h41,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        // reset state
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        code_base      = CB;
        @(negedge clk);
        chk_zero("reset");

        // table of instructions laid out back to back from offset 0
        clear_mem();
        pos = 0;
        for (int i = 0; i < 11; i++) begin
            for (int b = 0; b < vt[i].len; b++) begin
                mem[8'(pos + b)] = vt[i].bytes[8*b +: 8];
            end
            pos += vt[i].len;
        end
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        pos = 0;
        for (int i = 0; i < 11; i++) begin
            wait_valid(ok, 200);
            if (!ok) begin
                timeout($sformatf("vec%0d", i));
            end else begin
                chk($sformatf("vec%0d op", i), 64'(instr_opcode), 64'(vt[i].op));
                chk($sformatf("vec%0d imm", i), instr_imm, vt[i].imm);
                chk($sformatf("vec%0d has", i), 64'(instr_has_imm),
                    64'(vt[i].has));
                chk($sformatf("vec%0d pc", i), 64'(instr_pc), 64'(pos));
            end
            pos += vt[i].len;
        end
        chk("first read addr", 64'((rd_q.size() > 0) ? rd_q[0] : 32'h0),
            64'h100);
        chk("second read addr", 64'((rd_q.size() > 1) ? rd_q[1] : 32'h0),
            64'h101);

        // backpressure: call 3 held for 5 cycles, then i32.add
        clear_mem();
        mem[0] = 8'h10;
        mem[1] = 8'h03;
        mem[2] = 8'h6A;
        do_reset();
        pulse_start();
        wait_valid(ok, 100);
        if (!ok) timeout("bp call");
        chk("bp call op", 64'(instr_opcode), 64'h10);
        chk("bp call imm", instr_imm, 64'd3);
        chk("bp call has", 64'(instr_has_imm), 64'h1);
        chk("bp call pc", 64'(instr_pc), 64'h0);
        s_op  = instr_opcode;
        s_imm = instr_imm;
        s_has = instr_has_imm;
        s_pc  = instr_pc;
        bad   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!instr_valid || memory_read_en || instr_opcode != s_op ||
                instr_imm != s_imm || instr_has_imm != s_has ||
                instr_pc != s_pc) bad++;
        end
        chk("bp hold stable", 64'(bad), 64'h0);
        chk("bp no reads", 64'(rd_q.size()), 64'd2);
        instr_ready = 1'b1;
        @(negedge clk);
        wait_valid(ok, 100);
        if (!ok) timeout("bp add");
        chk("bp add op", 64'(instr_opcode), 64'h6A);
        chk("bp add has", 64'(instr_has_imm), 64'h0);
        chk("bp add imm", instr_imm, 64'h0);
        chk("bp add pc", 64'(instr_pc), 64'h2);

        // overlong LEB128: fault on the 6th immediate byte
        clear_mem();
        mem[0] = 8'h20;
        for (int i = 1; i <= 5; i++) mem[i] = 8'h80;
        mem[6]    = 8'h01;
        mem[8'h40] = 8'h6A;
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fault) break;
        end
        chk("leb fault", 64'(fault), 64'h1);
        chk("leb fault code", 64'(fault_code), 64'h1);
        chk("leb reads at fault", 64'(rd_q.size()), 64'd7);
        chk("leb last addr",
            64'((rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 32'h0), 64'h106);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (memory_read_en || instr_valid || !fault) bad++;
        end
        chk("fault quiet", 64'(bad), 64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("fault cleared", 64'(fault), 64'h0);
        wait_valid(ok, 100);
        if (!ok) timeout("post-fault");
        chk("post-fault op", 64'(instr_opcode), 64'h6A);
        chk("post-fault pc", 64'(instr_pc), 64'h40);

        // redirect while the second immediate byte is outstanding
        clear_mem();
        mem[0]     = 8'h20;
        mem[1]     = 8'h85;
        mem[2]     = 8'h01;
        mem[8'h40] = 8'h6A;
        do_reset();
        lat         = 3;
        instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (memory_read_en && addr == CB + 32'h2) break;
            @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid(ok, 200);
        if (!ok) timeout("redir");
        chk("redir op", 64'(instr_opcode), 64'h6A);
        chk("redir pc", 64'(instr_pc), 64'h40);
        chk("redir dropped read",
            64'((rd_q.size() > 2) ? rd_q[2] : 32'h0), 64'h102);
        chk("redir next read",
            64'((rd_q.size() > 3) ? rd_q[3] : 32'h0), 64'h140);
        lat = 0;

        // asynchronous reset mid-read and mid-emit
        clear_mem();
        mem[0] = 8'h41;
        mem[1] = 8'h05;
        do_reset();
        lat = 3;
        pulse_start();
        chk("pre-reset rd_en", 64'(memory_read_en), 64'h1);
        #1 rst_n = 1'b0;
        #1 chk_zero("reset mid-read");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_valid(ok, 200);
        if (!ok) timeout("pre-reset emit");
        #1 rst_n = 1'b0;
        #1 chk_zero("reset mid-emit");
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 0;
        @(negedge clk);
        rd_q.delete();
        instr_ready = 1'b1;
        pulse_start();
        wait_valid(ok, 100);
        if (!ok) timeout("resume");
        chk("resume first read",
            64'((rd_q.size() > 0) ? rd_q[0] : 32'h0), 64'h100);
        chk("resume op", 64'(instr_opcode), 64'h41);
        chk("resume imm", instr_imm, 64'd5);
        chk("resume pc", 64'(instr_pc), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wasm_fetch_decode.md
# wasm_fetch_decode

Parametrised instruction fetch/decode front end for the WebAssembly stack CPU. It fetches opcode bytes over the byte-wide memory handshake and decodes unsigned or signed LEB128 immediates, with widths chosen per opcode. It supports pipeline redirects and reports faults. Decoded instructions go to the execute stage over a valid/ready handshake, so fetch is decoupled from operand loading and execution.

## Interface
- ADDR_W, 32, memory address and PC width
- IMM_W, 64, immediate output width; legal values are 32 or 64
- PC_RESET, 0, PC offset loaded at reset
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- code_base  in  ADDR_W  code region base; sampled on start and on redirect
- start  in  1  one-cycle pulse; IDLE→FETCH_OP
- redirect_valid  in  1  flush and refetch from redirect_pc
- redirect_pc  in  ADDR_W  new PC offset, relative to code_base
- addr  out  ADDR_W  memory address; equals code_base + pc
- memory_read_en  out  1  read request
- data_out  in  8  memory read data; valid while memory_ready is high
- memory_ready  in  1  memory response strobe
- instr_valid  out  1  decoded instruction is available
- instr_ready  in  1  execute stage accepts the instruction
- instr_opcode  out  8  opcode byte
- instr_imm  out  IMM_W  decoded immediate; zero when the opcode has none
- instr_has_imm  out  1  opcode carries an immediate
- instr_pc  out  ADDR_W  PC offset of the opcode byte
- fault  out  1  sticky fault flag
- fault_code  out  2  1 = LEB128 too long; 2 = i64 immediate with IMM_W=32

## Operation
- Immediate classes:
  - U32: 0x0C br, 0x0D br_if, 0x10 call, 0x20 local.get, 0x21 local.set, 0x22 local.tee. At most 5 bytes; zero-extended.
  - S32: 0x41 i32.const. At most 5 bytes; sign-extended from bit 31 to IMM_W.
  - S64: 0x42 i64.const. At most 10 bytes.
  - All other opcodes, including 0x00, have no immediate and are passed through.
- LEB128 decoding:
  - Byte k contributes data_out[6:0] << 7k.
  - A byte with bit 7 set means another byte follows.
  - For signed classes, if the final byte has bit 6 set, every bit at or above 7(k+1) is set to 1.
  - Excess high bits in the final byte are truncated without checking.
- States:
  - IDLE: waits for start.
  - FETCH_OP: reads the opcode byte.
  - GAP: waits for memory_ready to drop.
  - IMM: reads immediate bytes.
  - EMIT: holds the decoded instruction until it is accepted.
  - FAULT: terminal until reset or redirect.
- Transitions:
  - FETCH_OP with ready → latch opcode and instr_pc, pc+1 → GAP.
  - GAP → IMM if the opcode has an immediate, otherwise → EMIT.
  - IMM with ready and bit 7 clear → GAP → EMIT.
  - EMIT with instr_valid && instr_ready → FETCH_OP.
- Faults:
  - Byte count exceeding the class maximum → FAULT, code 1.
  - 0x42 when IMM_W=32 → FAULT, code 2, detected at decode.
  - In FAULT: memory_read_en=0 and instr_valid=0.
- Redirect:
  - redirect_valid is latched into a pending flag.
  - If memory_read_en is low, the redirect applies on the next edge.
  - Otherwise the block waits for the current memory_ready and discards that byte.
  - Applying a redirect: pc←redirect_pc, instr_valid←0, fault cleared, state→FETCH_OP.
- Redirect and handshake in the same cycle: the handshake completes (the instruction counts as consumed) and the redirect PC wins.
- Redirect in IDLE also acts as start.

## Timing
- Reset values:
  - All outputs 0, including addr, memory_read_en, instr_* and fault.
  - pc=PC_RESET; state IDLE; pending redirect cleared.
- Memory handshake:
  - addr and memory_read_en are registered, and addr is held stable while memory_read_en=1.
  - data_out is captured on the first edge where memory_ready=1, and memory_read_en drops on that same edge.
  - No new request is issued until memory_ready has been sampled low (GAP state).
- Decode latency: instr_valid rises one cycle after the edge that captures the final byte of the instruction.
- Backpressure: while instr_valid=1 and instr_ready=0, all instr_* outputs stay stable and no fetch is issued.
- Fault assertion: fault rises on the edge that detects the violating byte.

## Structure
- Shared package wasm_pkg holds:
  - opcode localparams
  - fault code constants
  - immediate-class encoding (NONE/U32/S32/S64)
  - the opcode→class function, which the execute stage reuses
- Sub-module leb128_accum is sequential. It has:
  - inputs: clear, byte_valid, byte, class
  - outputs: value, done, overflow, plus a byte counter
- The top level holds the state machine, the PC, redirect handling and the output register.

## Test plan
- Bytes 0x41 0x7F at offset 0, code_base=0x100:
  - reads go to addr 0x100 and 0x101
  - output: instr_opcode=0x41, instr_imm=0xFFFF_FFFF_FFFF_FFFF, instr_pc=0
- 0x41 0x80 0x7F → instr_imm=−128 (0xFFFF_FFFF_FFFF_FF80); 0x41 0xE5 0x8E 0x26 → 624485.
- 0x10 0x03 followed by 0x6A:
  - instr_ready held low for 5 cycles: outputs stay stable and no memory_read_en during the hold
  - then the call is emitted with imm=3, followed by 0x6A with has_imm=0
- 0x20 then 0x80 ×5 then 0x01 → fault=1, fault_code=1 on the 6th immediate byte; memory_read_en stays 0 afterwards.
- Redirect mid-IMM:
  - redirect_valid to pc 0x40 while the second immediate byte is outstanding
  - the byte is discarded, no instr_valid is produced for that instruction, and the next read is code_base+0x40
- rst_n asserted while memory_read_en=1 and instr_valid=1:
  - all outputs go to 0 immediately
  - after release and start, fetch resumes at PC_RESET
